calc_cmd_parser: RTL and testbench

- Consumes the byte stream from the UART receive stage (8-bit `data` plus a one-cycle `rxdDataReady` strobe).
- Parses ASCII commands of the form `<A><op><B>=` into two binary operands and an opcode for the calculator datapath.
- Holds each decoded command until the datapath acknowledges it.
- Flags malformed input with a one-cycle error pulse.

---
 rtl/calc_cmd_parser.sv | 145 ++++++++++++++
 tb/tb_calc_cmd_parser.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_cmd_parser.sv
// ASCII command parser: turns "<A><op><B>=" byte streams into operands and an opcode.
// Optional macro CALC_CLEAR_KEY_EN makes 'C'/'c' abort a partial parse silently.
module calc_cmd_parser #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             rxdDataReady,
    output logic [WIDTH-1:0] operandA,
    output logic [WIDTH-1:0] operandB,
    output logic [1:0]       opcode,
    output logic             cmdValid,
    input  logic             cmdAck,
    output logic             cmdError,
    output logic             overrun
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {IDLE, OPA, OPB_WAIT, OPB, HOLD} state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] acc, accNext, opANext, opBNext;
    logic [CW-1:0]    cnt, cntNext;
    logic [1:0]       opNext, opDec;
    logic             errNext, ovrNext;
    logic             isDigit, isOp, isTerm, isSpace, isClear;
    logic             fail, abort, accOvf;
    logic [3:0]       digit;
    logic [WIDTH+3:0] prod;

    assign isDigit = (data >= 8'h30) && (data <= 8'h39);
    assign isOp    = (data == 8'h2B) || (data == 8'h2D) || (data == 8'h2A) || (data == 8'h2F);
    assign isTerm  = (data == 8'h3D) || (data == 8'h0D);
    assign isSpace = (data == 8'h20);
`ifdef CALC_CLEAR_KEY_EN
    assign isClear = (data == 8'h43) || (data == 8'h63);
`else
    assign isClear = 1'b0;
`endif

    assign digit  = data[3:0];
    assign prod   = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + (WIDTH+4)'(digit);
    // Overflow covers both value range and the digit-count limit (leading zeros included).
    assign accOvf = (prod[WIDTH+3:WIDTH] != '0) || (cnt == CW'(MAX_DIGITS));

    always_comb begin
        opDec = 2'b00;
        case (data)
            8'h2D:   opDec = 2'b01;
            8'h2A:   opDec = 2'b10;
            8'h2F:   opDec = 2'b11;
            default: opDec = 2'b00;
        endcase
    end

    assign cmdValid = (state == HOLD);

    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        opANext   = operandA;
        opBNext   = operandB;
        opNext    = opcode;
        errNext   = 1'b0;
        ovrNext   = 1'b0;
        fail      = 1'b0;
        abort     = 1'b0;
        if (state == HOLD) begin
            if (rxdDataReady) ovrNext = 1'b1;
            if (cmdAck) stateNext = IDLE;
        end else if (rxdDataReady && !isSpace) begin
            if (isClear) begin
                abort = 1'b1;
            end else begin
                case (state)
                    IDLE, OPB_WAIT: begin
                        if (isDigit) begin
                            accNext = WIDTH'(digit);
                            cntNext = CW'(1);
                            if (state == IDLE) stateNext = OPA;
                            else               stateNext = OPB;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                    OPA, OPB: begin
                        if (isDigit) begin
                            if (accOvf) begin
                                fail = 1'b1;
                            end else begin
                                accNext = prod[WIDTH-1:0];
                                cntNext = cnt + CW'(1);
                            end
                        end else if (state == OPA && isOp) begin
                            opANext   = acc;
                            opNext    = opDec;
                            accNext   = '0;
                            cntNext   = '0;
                            stateNext = OPB_WAIT;
                        end else if (state == OPB && isTerm) begin
                            opBNext   = acc;
                            accNext   = '0;
                            cntNext   = '0;
                            stateNext = HOLD;
                        end else begin
                            fail = 1'b1;
                        end
                    end
                    default: fail = 1'b1;
                endcase
            end
        end
        if (fail || abort) begin
            stateNext = IDLE;
            accNext   = '0;
            cntNext   = '0;
            errNext   = fail;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            operandA <= '0;
            operandB <= '0;
            opcode   <= '0;
            cmdError <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= stateNext;
            acc      <= accNext;
            cnt      <= cntNext;
            operandA <= opANext;
            operandB <= opBNext;
            opcode   <= opNext;
            cmdError <= errNext;
            overrun  <= ovrNext;
        end
    end
endmodule

// File: tb/tb_calc_cmd_parser.sv
// Scoreboard bench for calc_cmd_parser: per-byte pulse expectations and decoded commands are queued and compared.
module tb_calc_cmd_parser;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  data = '0;
    logic        rxdDataReady = 1'b0;
    logic [15:0] operandA, operandB;
    logic [1:0]  opcode;
    logic        cmdValid, cmdAck = 1'b0, cmdError, overrun;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } cmd_t;

    logic [3:0] expQ[$];
    logic [3:0] obsQ[$];
    cmd_t       cmdQ[$];
    logic       lastValid;

    calc_cmd_parser #(.WIDTH(16), .MAX_DIGITS(5)) dut (
        .clk(clk), .reset(reset), .data(data), .rxdDataReady(rxdDataReady),
        .operandA(operandA), .operandB(operandB), .opcode(opcode),
        .cmdValid(cmdValid), .cmdAck(cmdAck), .cmdError(cmdError), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Expected {err,ovr} on the strobe cycle, then both low on the following cycle.
    task automatic sendByte(input logic [7:0] b, input logic e, input logic o);
        logic [3:0] obs;
        expQ.push_back({e, o, 2'b00});
        @(negedge clk);
        data = b;
        rxdDataReady = 1'b1;
        @(posedge clk);
        #1;
        obs[3:2] = {cmdError, overrun};
        lastValid = cmdValid;
        rxdDataReady = 1'b0;
        @(posedge clk);
        #1;
        obs[1:0] = {cmdError, overrun};
        obsQ.push_back(obs);
    endtask

    task automatic sendStr(input string s);
        for (int i = 0; i < s.len(); i++) sendByte(s[i], 1'b0, 1'b0);
    endtask

    task automatic ackCmd();
        @(negedge clk);
        cmdAck = 1'b1;
        @(posedge clk);
        #1;
        cmdAck = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({operandA, operandB, opcode, cmdValid, cmdError, overrun} !== '0)
            $display("FAIL reset_state: got A=%0d B=%0d op=%b v=%b e=%b o=%b want all 0",
                     operandA, operandB, opcode, cmdValid, cmdError, overrun);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic_hold();
        logic [3:0] e, o;
        cmd_t c;
        logic stable;
        sendStr("12+34");
        total++;
        if (cmdValid !== 1'b0) $display("FAIL early_valid: got %b want 0", cmdValid);
        else passed++;
        cmdQ.push_back('{16'd12, 16'd34, 2'b00});
        sendByte("=", 1'b0, 1'b0);
        c = cmdQ.pop_front();
        total++;
        if (lastValid !== 1'b1 || cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_basic: got v=%b/%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     lastValid, cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op) stable = 1'b0;
        end
        total++;
        if (stable !== 1'b1) $display("FAIL hold_stable: got %b want 1", stable);
        else passed++;
        ackCmd();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); total++;
            if (o !== e) $display("FAIL pulses_basic: got err/ovr=%b want %b", o, e);
            else passed++;
        end
    endtask

    task automatic test_max_and_ack();
        logic [3:0] e, o;
        cmd_t c;
        sendStr("65535*2");
        cmdQ.push_back('{16'd65535, 16'd2, 2'b10});
        sendByte(8'h0D, 1'b0, 1'b0);
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_max: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
        total++;
        if (cmdValid !== 1'b0) $display("FAIL ack_fall: got %b want 0", cmdValid);
        else passed++;
        cmdQ.push_back('{16'd7, 16'd1, 2'b01});
        sendStr("7-1=");
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_after_ack: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); total++;
            if (o !== e) $display("FAIL pulses_max: got err/ovr=%b want %b", o, e);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [3:0] e, o;
        cmd_t c;
        sendStr("6553");
        sendByte("6", 1'b1, 1'b0);
        sendByte("+", 1'b1, 1'b0);
        total++;
        if (operandA !== 16'd7 || operandB !== 16'd1 || opcode !== 2'b01 || cmdValid !== 1'b0)
            $display("FAIL err_keeps_ops: got A=%0d B=%0d op=%b v=%b want 7 1 01 0",
                     operandA, operandB, opcode, cmdValid);
        else passed++;
        sendStr("00000");
        sendByte("1", 1'b1, 1'b0);
        cmdQ.push_back('{16'd1, 16'd1, 2'b11});
        sendStr("1/1=");
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_after_ovf: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); total++;
            if (o !== e) $display("FAIL pulses_ovf: got err/ovr=%b want %b", o, e);
            else passed++;
        end
    endtask

    task automatic test_syntax_errors();
        logic [3:0] e, o;
        cmd_t c;
        // '+' errors in IDLE, '5' then starts a fresh operand, '=' errors in OPA.
        sendByte("+", 1'b1, 1'b0);
        sendByte("5", 1'b0, 1'b0);
        sendByte("=", 1'b1, 1'b0);
        sendByte("5", 1'b0, 1'b0);
        sendByte("+", 1'b0, 1'b0);
        sendByte("=", 1'b1, 1'b0);
        total++;
        if (cmdValid !== 1'b0) $display("FAIL syntax_no_valid: got %b want 0", cmdValid);
        else passed++;
        cmdQ.push_back('{16'd1, 16'd2, 2'b00});
        sendStr("1 + 2 =");
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_spaces: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); total++;
            if (o !== e) $display("FAIL pulses_syntax: got err/ovr=%b want %b", o, e);
            else passed++;
        end
    endtask

    task automatic test_overrun();
        logic [3:0] e, o;
        cmd_t c;
        sendStr("9-3=");
        sendByte("4", 1'b0, 1'b1);
        c = '{16'd9, 16'd3, 2'b01};
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL overrun_hold: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        @(negedge clk);
        data = "5";
        rxdDataReady = 1'b1;
        cmdAck = 1'b1;
        @(posedge clk);
        #1;
        rxdDataReady = 1'b0;
        cmdAck = 1'b0;
        total++;
        if (overrun !== 1'b1 || cmdValid !== 1'b0 || cmdError !== 1'b0)
            $display("FAIL ack_and_byte: got ovr=%b v=%b err=%b want 1 0 0", overrun, cmdValid, cmdError);
        else passed++;
        cmdQ.push_back('{16'd2, 16'd2, 2'b00});
        sendStr("2+2=");
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL byte_dropped: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); total++;
            if (o !== e) $display("FAIL pulses_overrun: got err/ovr=%b want %b", o, e);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] e, o;
        cmd_t c;
        sendStr("12+3");
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({operandA, operandB, opcode, cmdValid, cmdError, overrun} !== '0)
            $display("FAIL reset_mid: got A=%0d B=%0d op=%b v=%b e=%b o=%b want all 0",
                     operandA, operandB, opcode, cmdValid, cmdError, overrun);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        cmdQ.push_back('{16'd8, 16'd8, 2'b00});
        sendStr("8+8=");
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_after_reset: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); total++;
            if (o !== e) $display("FAIL pulses_reset: got err/ovr=%b want %b", o, e);
            else passed++;
        end
    endtask

    task automatic test_clear_key();
        logic [3:0] e, o;
        cmd_t c;
`ifdef CALC_CLEAR_KEY_EN
        cmdQ.push_back('{16'd3, 16'd4, 2'b00});
        sendStr("12+C3+4=");
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_clear: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
`else
        sendByte("C", 1'b1, 1'b0);
        sendByte("1", 1'b0, 1'b0);
        sendByte("c", 1'b1, 1'b0);
        cmdQ.push_back('{16'd3, 16'd4, 2'b00});
        sendStr("3+4=");
        c = cmdQ.pop_front();
        total++;
        if (cmdValid !== 1'b1 || operandA !== c.a || operandB !== c.b || opcode !== c.op)
            $display("FAIL cmd_after_c: got v=%b A=%0d B=%0d op=%b want 1 A=%0d B=%0d op=%b",
                     cmdValid, operandA, operandB, opcode, c.a, c.b, c.op);
        else passed++;
        ackCmd();
`endif
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); total++;
            if (o !== e) $display("FAIL pulses_clear: got err/ovr=%b want %b", o, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_hold();
        test_max_and_ack();
        test_overflow();
        test_syntax_errors();
        test_overrun();
        test_reset_mid();
        test_clear_key();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
